// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester, CPU and memory-side signal bundle for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  ld_req;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_ack;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic [1:0]            grant_id;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, d_req, d_we, d_addr, d_wdata,
           f_req, f_addr, mem_rdata,
    output ld_ack, d_ack, f_ack, rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy, grant_id
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, d_req, d_we, d_addr, d_wdata,
           f_req, f_addr, mem_rdata,
    input  ld_ack, d_ack, f_ack, rdata, mem_en, mem_we, mem_addr,
           mem_wdata, busy, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : fixed-priority loader/data/fetch arbiter for a single-port
//               memory, with a fetch anti-starvation guard
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int c_sw = $clog2(STARVE_LIMIT + 1);
  localparam int c_ww = $clog2(MEM_LATENCY + 1);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_LIMIT);
  localparam logic [c_ww-1:0] c_wait_load  = c_ww'(MEM_LATENCY);
  localparam logic [c_ww-1:0] c_wait_last  = c_ww'(1);
  localparam logic [1:0]      c_gnt_ld     = 2'd1;
  localparam logic [1:0]      c_gnt_d      = 2'd2;
  localparam logic [1:0]      c_gnt_f      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t                state_q;
  logic [c_sw-1:0]       starve_q;
  logic [c_ww-1:0]       wcnt_q;
  logic                  we_q;
  logic [1:0]            grant_q;
  logic                  ld_ack_q;
  logic                  d_ack_q;
  logic                  f_ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      wcnt_q      <= '0;
      we_q        <= 1'b0;
      grant_q     <= 2'd0;
      ld_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      f_ack_q     <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ld_req || bus.d_req || bus.f_req) begin
            state_q  <= S_ACCESS;
            mem_en_q <= 1'b1;
            if (bus.ld_req) begin
              grant_q     <= c_gnt_ld;
              mem_addr_q  <= bus.ld_addr;
              mem_wdata_q <= bus.ld_wdata;
              we_q        <= 1'b1;
              mem_we_q    <= 1'b1;
              if (!bus.f_req) starve_q <= '0;
            end else if (bus.f_req && (starve_q == c_starve_max)) begin
              grant_q    <= c_gnt_f;
              mem_addr_q <= bus.f_addr;
              we_q       <= 1'b0;
              mem_we_q   <= 1'b0;
              starve_q   <= '0;
            end else if (bus.d_req) begin
              grant_q     <= c_gnt_d;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              we_q        <= bus.d_we;
              mem_we_q    <= bus.d_we;
              // Only data grants made while fetch waits count toward forcing fetch
              if (!bus.f_req) starve_q <= '0;
              else if (starve_q != c_starve_max) starve_q <= starve_q + 1'b1;
            end else begin
              grant_q    <= c_gnt_f;
              mem_addr_q <= bus.f_addr;
              we_q       <= 1'b0;
              mem_we_q   <= 1'b0;
              starve_q   <= '0;
            end
          end
        end
        S_ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (we_q) begin
            state_q  <= S_ACK;
            ld_ack_q <= (grant_q == c_gnt_ld);
            d_ack_q  <= (grant_q == c_gnt_d);
            f_ack_q  <= (grant_q == c_gnt_f);
          end else begin
            state_q <= S_WAIT;
            wcnt_q  <= c_wait_load;
          end
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 1'b1;
          if (wcnt_q == c_wait_last) begin
            rdata_q  <= bus.mem_rdata;
            state_q  <= S_ACK;
            ld_ack_q <= (grant_q == c_gnt_ld);
            d_ack_q  <= (grant_q == c_gnt_d);
            f_ack_q  <= (grant_q == c_gnt_f);
          end
        end
        S_ACK: begin
          ld_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          f_ack_q  <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ack    = ld_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.f_ack     = f_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant_id  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : randomized self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int ML1 = 1;
  localparam int ML3 = 3;
  localparam int SL  = 4;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML1), .STARVE_LIMIT(SL))
    u_dut1 (.clk_i(clk), .rst_i(rst1), .bus(if1.slave));
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML3), .STARVE_LIMIT(SL))
    u_dut3 (.clk_i(clk), .rst_i(rst3), .bus(if3.slave));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory device behind u_dut1: data is visible on mem_rdata only in the
  // cycle MEM_LATENCY after the enable cycle, junk otherwise.
  logic [DW-1:0] dev_mem [0:255];
  logic [AW-1:0] rd_addr;
  int            rd_cnt;
  int            cyc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst1) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 16'(i * 37 + 16'h1234);
      rd_cnt <= 0;
    end else begin
      if (if1.mem_en && if1.mem_we) dev_mem[if1.mem_addr[7:0]] <= if1.mem_wdata;
      if (if1.mem_en && !if1.mem_we) begin
        rd_addr <= if1.mem_addr;
        rd_cnt  <= ML1;
      end else if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  assign if1.mem_rdata = (rd_cnt == 1) ? dev_mem[rd_addr[7:0]] : (16'hDEAD ^ cyc[15:0]);

  // Reference model state
  logic [DW-1:0] mdl_mem [0:255];
  logic [3:1]    pend;
  logic [AW-1:0] p_addr  [1:3];
  logic [DW-1:0] p_wdata [1:3];
  logic          p_we    [1:3];
  int            starve;
  int            last_w;

  task automatic drive_all();
    if1.ld_req   = pend[1];
    if1.ld_addr  = p_addr[1];
    if1.ld_wdata = p_wdata[1];
    if1.d_req    = pend[2];
    if1.d_we     = p_we[2];
    if1.d_addr   = p_addr[2];
    if1.d_wdata  = p_wdata[2];
    if1.f_req    = pend[3];
    if1.f_addr   = p_addr[3];
  endtask

  task automatic new_req(input int p);
    logic [AW-1:0] a;
    a       = 16'($urandom);
    a[7:0]  = 8'($urandom_range(0, 15));
    pend[p]    = 1'b1;
    p_addr[p]  = a;
    p_wdata[p] = 16'($urandom);
    p_we[p]    = 1'($urandom);
    drive_all();
  endtask

  // Called at the negedge of an IDLE cycle with some request pending;
  // returns at the negedge of the ack cycle.
  task automatic serve_one(output int w);
    int            lat;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    if (pend[1])                        w = 1;
    else if (pend[3] && starve == SL)   w = 3;
    else if (pend[2])                   w = 2;
    else                                w = 3;
    if (!pend[3])                       starve = 0;
    else if (w == 3)                    starve = 0;
    else if (w == 2 && starve < SL)     starve = starve + 1;
    a   = p_addr[w];
    wd  = p_wdata[w];
    we  = (w == 1) ? 1'b1 : (w == 3) ? 1'b0 : p_we[w];
    lat = we ? 2 : 2 + ML1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq("mem_en_access", if1.mem_en, 1);
        check_eq("mem_we_access", if1.mem_we, we);
        check_eq("mem_addr", if1.mem_addr, a);
        if (we) check_eq("mem_wdata", if1.mem_wdata, wd);
      end else begin
        check_eq("mem_en_off", if1.mem_en, 0);
      end
      check_eq("grant_id", if1.grant_id, w);
      check_eq("busy_active", if1.busy, 1);
      check_eq("acks", {if1.ld_ack, if1.d_ack, if1.f_ack}, (c == lat) ? (3'b100 >> (w - 1)) : 3'b000);
    end
    if (!we) check_eq("rdata", if1.rdata, mdl_mem[a[7:0]]);
    else     mdl_mem[a[7:0]] = wd;
    pend[w] = 1'b0;
    last_w  = w;
    drive_all();
  endtask

  task automatic step(output int w);
    check_eq("idle_busy", if1.busy, 0);
    check_eq("idle_acks", {if1.ld_ack, if1.d_ack, if1.f_ack}, 0);
    check_eq("idle_mem_en", if1.mem_en, 0);
    check_eq("idle_grant", if1.grant_id, last_w);
    w = 0;
    if (pend != 3'b000) serve_one(w);
    @(negedge clk);
  endtask

  task automatic check_reset3(input string tag);
    check_eq({tag, "_busy"}, if3.busy, 0);
    check_eq({tag, "_mem_en"}, if3.mem_en, 0);
    check_eq({tag, "_mem_we"}, if3.mem_we, 0);
    check_eq({tag, "_mem_addr"}, if3.mem_addr, 0);
    check_eq({tag, "_rdata"}, if3.rdata, 0);
    check_eq({tag, "_grant"}, if3.grant_id, 0);
    check_eq({tag, "_acks"}, {if3.ld_ack, if3.d_ack, if3.f_ack}, 0);
  endtask

  // Latency-3 fetch on u_dut3; mem_rdata carries the real value only in cycle 4.
  task automatic fetch3(input logic [AW-1:0] a, input logic [DW-1:0] val);
    if3.f_addr = a;
    if3.f_req  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if3.mem_rdata = (c == 4) ? val : (16'h0F0F ^ 16'(c));
      if (c == 1) begin
        check_eq("ml3_mem_en", if3.mem_en, 1);
        check_eq("ml3_mem_addr", if3.mem_addr, a);
      end
      check_eq("ml3_f_ack", if3.f_ack, (c == 5));
    end
    check_eq("ml3_rdata", if3.rdata, val);
    check_eq("ml3_grant", if3.grant_id, 3);
    if3.f_req = 1'b0;
    @(negedge clk);
  endtask

  int w;

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    pend = 3'b000;
    for (int p = 1; p <= 3; p++) begin
      p_addr[p] = '0; p_wdata[p] = '0; p_we[p] = 1'b0;
    end
    drive_all();
    if3.ld_req = 1'b0; if3.ld_addr = '0; if3.ld_wdata = '0;
    if3.d_req = 1'b0; if3.d_we = 1'b0; if3.d_addr = '0; if3.d_wdata = '0;
    if3.f_req = 1'b0; if3.f_addr = '0; if3.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 16'(i * 37 + 16'h1234);
    starve = 0;
    last_w = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", if1.busy, 0);
    check_eq("rst_mem_en", if1.mem_en, 0);
    check_eq("rst_rdata", if1.rdata, 0);
    check_eq("rst_grant", if1.grant_id, 0);
    check_eq("rst_acks", {if1.ld_ack, if1.d_ack, if1.f_ack}, 0);
    check_reset3("rst3");
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    // Lone fetch, then a data write to the top of the address map
    pend[3] = 1'b1; p_addr[3] = 16'h0010; drive_all();
    step(w);
    check_eq("first_fetch_grant", w, 3);
    pend[2] = 1'b1; p_addr[2] = 16'hFFF0; p_wdata[2] = 16'd42; p_we[2] = 1'b1; drive_all();
    step(w);
    check_eq("data_write_grant", w, 2);

    // All three at once: loader, data, fetch
    new_req(1); new_req(2); new_req(3);
    for (int k = 1; k <= 3; k++) begin
      step(w);
      check_eq("simul_order", w, k);
    end

    // Data and fetch held continuously
    for (int k = 0; k < 10; k++) begin
      if (!pend[2]) new_req(2);
      if (!pend[3]) new_req(3);
      step(w);
      check_eq("starve_seq", w, ((k % 5) == 4) ? 3 : 2);
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int p = 1; p <= 3; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0) new_req(p);
      step(w);
    end
    pend = 3'b000;
    drive_all();

    // Latency-3 instance: normal fetch, reset during WAIT, then recovery
    fetch3(16'h0020, 16'h3C3C);
    if3.f_addr = 16'h0030;
    if3.f_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst3 = 1'b1;
    #1 check_reset3("rst_in_wait");
    if3.f_req = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("no_ack_after_rst", {if3.ld_ack, if3.d_ack, if3.f_ack}, 0);
      check_eq("idle_after_rst", if3.busy, 0);
    end
    fetch3(16'h0040, 16'h7E7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
